// File: rtl/tone_seq_player_if.sv
// Control, status and note-table bus of the tone sequence player.
//   start/stop/pause/loop_en : playback control into the player
//   rom_addr                 : note table address from the player
//   rom_data                 : {half_period, dur} returned by the table one cycle after rom_addr
//   beep/busy/done           : buzzer drive and status from the player
// The slave modport is the player; the master modport is whoever drives it and hosts the table.
interface tone_seq_player_if #(
    parameter int ADDR_W = 5,
    parameter int ROM_W  = 24
);
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [ROM_W-1:0]  rom_data;
    logic              beep;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, pause, loop_en, rom_data,
        input  rom_addr, beep, busy, done
    );

    modport slave (
        input  start, stop, pause, loop_en, rom_data,
        output rom_addr, beep, busy, done
    );
endinterface

// File: rtl/tone_seq_player.sv
// Melody player for the piezo beeper. Walks a note table of {half_period, dur}
// entries, plays each note as a 50%-duty square wave for dur beats, treats
// half_period==0 as a rest and dur==0 as end of song. Supports stop, pause
// and looping; every output is a register.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active high
//   bus  : tone_seq_player_if.slave (start/stop/pause/loop_en in, rom_addr out,
//          rom_data in with one cycle read latency, beep/busy/done out)
module tone_seq_player #(
    parameter int BEAT_DIV = 1250000,
    parameter int DEPTH    = 32,
    parameter int PER_W    = 20,
    parameter int DUR_W    = 4,
    localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int BEAT_W  = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1
) (
    input  logic             clk,
    input  logic             rst,
    tone_seq_player_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        PLAY  = 2'd3
    } state_t;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              beep_q, beep_d;
    logic              busy_q;
    logic              done_q, done_d;
    // phase_q is the square-wave level; beep_q is phase_q gated by pause/rest/note end
    logic              phase_q, phase_d;
    logic [PER_W-1:0]  half_q, half_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [PER_W-1:0]  tone_q, tone_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              end_song;

    logic [PER_W-1:0]  rom_half;
    logic [DUR_W-1:0]  rom_dur;

    assign rom_half = bus.rom_data[PER_W+DUR_W-1:DUR_W];
    assign rom_dur  = bus.rom_data[DUR_W-1:0];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        beep_d   = beep_q;
        done_d   = 1'b0;
        phase_d  = phase_q;
        half_d   = half_q;
        dur_d    = dur_q;
        tone_d   = tone_q;
        beat_d   = beat_q;
        end_song = 1'b0;

        if (bus.stop) begin
            state_d = IDLE;
            addr_d  = '0;
            beep_d  = 1'b0;
            phase_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        addr_d  = '0;
                        state_d = FETCH;
                    end
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    if (rom_dur == '0) begin
                        end_song = 1'b1;
                    end else begin
                        half_d  = rom_half;
                        dur_d   = rom_dur;
                        tone_d  = '0;
                        beat_d  = '0;
                        phase_d = 1'b0;
                        beep_d  = 1'b0;
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    if (bus.pause) begin
                        // counters and address hold; only the output is silenced
                        beep_d = 1'b0;
                    end else begin
                        if (half_q != '0) begin
                            if (tone_q == half_q - PER_W'(1)) begin
                                phase_d = ~phase_q;
                                tone_d  = '0;
                            end else begin
                                tone_d = tone_q + PER_W'(1);
                            end
                        end
                        beep_d = phase_d;
                        if (beat_q == BEAT_LAST) begin
                            beat_d = '0;
                            dur_d  = dur_q - DUR_W'(1);
                            if (dur_q == DUR_W'(1)) begin
                                beep_d  = 1'b0;
                                phase_d = 1'b0;
                                // the last table entry never wraps the address
                                if (addr_q == ADDR_LAST) begin
                                    end_song = 1'b1;
                                end else begin
                                    addr_d  = addr_q + ADDR_W'(1);
                                    state_d = FETCH;
                                end
                            end
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end
                end
            endcase

            if (end_song) begin
                if (bus.loop_en) begin
                    addr_d  = '0;
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beep_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            phase_q <= 1'b0;
            half_q  <= '0;
            dur_q   <= '0;
            tone_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beep_q  <= beep_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
            phase_q <= phase_d;
            half_q  <= half_d;
            dur_q   <= dur_d;
            tone_q  <= tone_d;
            beat_q  <= beat_d;
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.beep     = beep_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_tone_seq_player.sv
// Bench for tone_seq_player (BEAT_DIV=10, DEPTH=4, PER_W=8, DUR_W=4).
// Holds the note table, a behavioural reference of the player, a per-cycle
// compare process and directed scenarios with hand-computed expectations,
// followed by randomized tables and control traffic.
module tb_tone_seq_player;
    localparam int BD    = 10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   c0  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [11:0] rom_tbl [0:DEPTH-1];

    tone_seq_player_if #(.ADDR_W(2), .ROM_W(12)) bus ();

    tone_seq_player #(.BEAT_DIV(BD), .DEPTH(DEPTH), .PER_W(8), .DUR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // note table with one cycle read latency
    always @(posedge clk) bus.rom_data <= rom_tbl[bus.rom_addr];

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 address presented, 2 data returned, 3 sounding a note.
    // Within a note, t counts un-paused cycles; the square wave level is
    // floor(t/half_period) mod 2 and the note lasts dur*BD such cycles.
    int m_mode = 0, m_addr = 0, m_hp = 0, m_dur = 0, m_t = 0;
    bit m_beep = 0, m_busy = 0, m_done = 0, m_end = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_addr = 0; m_hp = 0; m_dur = 0; m_t = 0;
            m_beep = 0; m_busy = 0; m_done = 0;
        end else begin
            m_end  = 0;
            m_done = 0;
            if (bus.stop) begin
                m_mode = 0; m_addr = 0; m_beep = 0;
            end else begin
                case (m_mode)
                    0: if (bus.start) begin m_addr = 0; m_mode = 1; end
                    1: m_mode = 2;
                    2: begin
                        m_hp  = int'(rom_tbl[m_addr][11:4]);
                        m_dur = int'(rom_tbl[m_addr][3:0]);
                        if (m_dur == 0) m_end = 1;
                        else begin m_t = 0; m_beep = 0; m_mode = 3; end
                    end
                    default: begin
                        if (bus.pause) m_beep = 0;
                        else begin
                            m_t++;
                            if (m_t == m_dur * BD) begin
                                m_beep = 0;
                                if (m_addr == DEPTH - 1) m_end = 1;
                                else begin m_addr++; m_mode = 1; end
                            end else begin
                                m_beep = (m_hp != 0) && (((m_t / m_hp) % 2) == 1);
                            end
                        end
                    end
                endcase
                if (m_end) begin
                    if (bus.loop_en) begin m_addr = 0; m_mode = 1; end
                    else begin m_mode = 0; m_done = 1; end
                end
            end
            m_busy = (m_mode != 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
            check("beep", 32'(bus.beep), 32'(m_beep));
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("done", 32'(bus.done), 32'(m_done));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_entry(input int i, input int hp, input int dur);
        rom_tbl[i[1:0]] = {8'(hp), 4'(dur)};
    endtask

    task automatic pulse_start();
        c0 = cyc;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    // Observe outputs at negedges; k = cycles since the start pulse.
    // Optionally raises pause at k==pf and drops it at k==pt.
    task automatic run_obs(input int budget, input int pf, input int pt, input bit until_done,
                           output int lat, output int hi, output int rises,
                           output int dones, output int addr0_at);
        bit prev;
        bit seen_nz;
        int k;
        lat = -1; hi = 0; rises = 0; dones = 0; addr0_at = -1;
        prev = 1'b0; seen_nz = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            k = cyc - c0;
            if (bus.beep) hi++;
            if (bus.beep && !prev) rises++;
            prev = bus.beep;
            if (bus.rom_addr != 2'd0) seen_nz = 1'b1;
            else if (seen_nz && addr0_at < 0) addr0_at = k;
            if (k == pf) bus.pause = 1'b1;
            if (k == pt) bus.pause = 1'b0;
            if (bus.done) begin
                dones++;
                if (lat < 0) lat = k;
                if (until_done) break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, hi, rises, dones, a0;
        bit found;
        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.loop_en = 0;
        for (int i = 0; i < DEPTH; i++) rom_tbl[i] = '0;

        #2 rst = 1'b1;
        @(negedge clk);
        check("reset_beep", 32'(bus.beep), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_addr", 32'(bus.rom_addr), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        tick(3);

        // basic song: tone, rest, tone, end marker
        set_entry(0, 5, 2); set_entry(1, 0, 1); set_entry(2, 3, 1); set_entry(3, 9, 0);
        tick(1);
        pulse_start();
        run_obs(200, -1, -1, 1'b1, lat, hi, rises, dones, a0);
        check("song_done_cycle", 32'(lat), 49);
        check("song_beep_high_cycles", 32'(hi), 14);
        check("song_beep_rises", 32'(rises), 4);
        tick(3);

        // looping: no done, address returns to 0, second pass identical
        bus.loop_en = 1'b1;
        pulse_start();
        run_obs(95, -1, -1, 1'b0, lat, hi, rises, dones, a0);
        check("loop_dones", 32'(dones), 0);
        check("loop_addr_back_to_0", 32'(a0), 49);
        check("loop_beep_rises", 32'(rises), 8);
        #4 bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0; bus.loop_en = 1'b0;
        tick(2);

        // full table without an end marker
        set_entry(0, 2, 1); set_entry(1, 0, 1); set_entry(2, 1, 1); set_entry(3, 4, 2);
        tick(1);
        pulse_start();
        run_obs(200, -1, -1, 1'b1, lat, hi, rises, dones, a0);
        check("full_done_cycle", 32'(lat), 59);
        check("full_addr_at_end", 32'(bus.rom_addr), 3);
        check("full_beep_high_cycles", 32'(hi), 17);
        check("full_beep_rises", 32'(rises), 9);
        tick(3);

        // pause for 17 cycles in the middle of a note
        set_entry(0, 5, 2); set_entry(1, 0, 0);
        tick(1);
        pulse_start();
        run_obs(200, 10, 27, 1'b1, lat, hi, rises, dones, a0);
        check("pause_done_cycle", 32'(lat), 42);
        check("pause_beep_high_cycles", 32'(hi), 10);
        check("pause_beep_rises", 32'(rises), 3);
        tick(3);

        // stop during a note, then stop+start together, then start ignored while busy
        set_entry(0, 1, 1); set_entry(1, 1, 4); set_entry(2, 1, 4); set_entry(3, 0, 0);
        tick(1);
        pulse_start();
        tick(19);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        check("stop_busy", 32'(bus.busy), 0);
        check("stop_beep", 32'(bus.beep), 0);
        check("stop_addr", 32'(bus.rom_addr), 0);
        check("stop_done", 32'(bus.done), 0);
        pulse_start();
        tick(19);
        bus.stop = 1'b1; bus.start = 1'b1;
        tick(1);
        bus.stop = 1'b0; bus.start = 1'b0;
        check("stopstart_busy", 32'(bus.busy), 0);
        check("stopstart_beep", 32'(bus.beep), 0);
        check("stopstart_addr", 32'(bus.rom_addr), 0);
        tick(3);
        check("stopstart_stays_idle", 32'(bus.busy), 0);
        pulse_start();
        tick(7);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(20);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        tick(2);

        // asynchronous reset in the middle of a note
        pulse_start();
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if (bus.rom_addr == 2'd1 && bus.beep) found = 1'b1;
        end
        check("rst_setup_reached", 32'(found), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_beep", 32'(bus.beep), 0);
        check("async_rst_busy", 32'(bus.busy), 0);
        check("async_rst_addr", 32'(bus.rom_addr), 0);
        #1 rst = 1'b0;
        tick(10);
        check("after_rst_idle", 32'(bus.busy), 0);

        // randomized tables and control traffic
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < DEPTH; i++)
                set_entry(i, $urandom_range(0, 6),
                          ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3));
            bus.loop_en = 1'($urandom_range(0, 1));
            tick(1);
            for (int n = 0; n < 300; n++) begin
                bus.start = ($urandom_range(0, 9) == 0);
                bus.stop  = ($urandom_range(0, 79) == 0);
                if ($urandom_range(0, 11) == 0) bus.pause = ~bus.pause;
                if ($urandom_range(0, 99) == 0) bus.loop_en = ~bus.loop_en;
                tick(1);
            end
            bus.start = 0; bus.pause = 0; bus.stop = 1'b1;
            tick(1);
            bus.stop = 0;
            tick(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
